mul_accum_stage: RTL



---
 rtl/mul_accum_stage.sv | 106 ++++++++++
 1 files changed

// File: rtl/mul_accum_stage.sv
// Saturating multiply-accumulate back end: sums a programmed number of unsigned
// products from the 4-bit multiplier and hands the total over a held valid/ready port.
module mul_accum_stage #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 10,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [PROD_W-1:0] prod_in,
   input  logic              prod_valid,
   output logic              prod_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic              overflow,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

   localparam logic [ACC_W-1:0] ACC_MAX = '1;
   localparam logic [LEN_W:0]   CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

   state_t             r_state;
   logic [ACC_W-1:0]   r_acc;
   logic [LEN_W:0]     r_cnt;
   logic               r_ovf;
   logic               r_prod_ready;
   logic               r_acc_valid;
   logic               r_busy;

   logic [ACC_W:0]     w_sum;
   logic [LEN_W:0]     w_terms;
   logic               w_sat;

   // One spare bit on the sum makes the carry out the saturation flag.
   assign w_sum   = {1'b0, r_acc} + {{(ACC_W+1-PROD_W){1'b0}}, prod_in};
   assign w_sat   = w_sum[ACC_W];
   assign w_terms = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_ovf        <= 1'b0;
         r_prod_ready <= 1'b0;
         r_acc_valid  <= 1'b0;
         r_busy       <= 1'b0;
      end else if (ena) begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cnt        <= w_terms;
                  r_acc        <= '0;
                  r_ovf        <= 1'b0;
                  r_state      <= S_ACCUM;
                  r_prod_ready <= 1'b1;
                  r_busy       <= 1'b1;
               end
            end
            S_ACCUM: begin
               if (prod_valid) begin
                  if (w_sat) begin
                     r_acc <= ACC_MAX;
                     r_ovf <= 1'b1;
                  end else begin
                     r_acc <= w_sum[ACC_W-1:0];
                  end
                  r_cnt <= r_cnt - CNT_ONE;
                  if (r_cnt == CNT_ONE) begin
                     r_state      <= S_DONE;
                     r_prod_ready <= 1'b0;
                     r_acc_valid  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               // start in this cycle is deliberately dropped; a new run begins from IDLE.
               if (acc_ready) begin
                  r_state     <= S_IDLE;
                  r_acc_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_prod_ready <= 1'b0;
               r_acc_valid  <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   assign prod_ready = r_prod_ready;
   assign acc_valid  = r_acc_valid;
   assign busy       = r_busy;
   assign acc_out    = r_acc;
   assign overflow   = r_ovf;

endmodule
